// File: rtl/dispatch_arbiter_if.sv
// Dispatch request/grant bundle between the per-FU skid buffers and the arbiter.
// Handshake: requester i transfers in the cycle where req_valid[i] & grant[i]; the buffer pops on that edge.
interface dispatch_arbiter_if;
  logic [2:0] req_valid;
  logic [2:0] rs_has_space;
  logic [2:0] grant;
  logic       grant_valid;
  logic [1:0] grant_idx;

  modport master (
    output req_valid,
    output rs_has_space,
    input  grant,
    input  grant_valid,
    input  grant_idx
  );

  modport slave (
    input  req_valid,
    input  rs_has_space,
    output grant,
    output grant_valid,
    output grant_idx
  );
endinterface

// File: rtl/dispatch_arbiter.sv
// One-grant-per-cycle dispatch arbiter with ROB credit tracking and starvation aging.
// Define DISPATCH_ARB_RR_EN for a round-robin base policy; otherwise fixed priority ALU > branch > LSU.
module dispatch_arbiter #(
  parameter int ROB_DEPTH    = 16,
  parameter int STARVE_LIMIT = 8,
  parameter int OCC_W        = $clog2(ROB_DEPTH + 1),
  parameter int AGE_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  dispatch_arbiter_if.slave  disp,
  input  logic               rob_retire,
  input  logic               mispredict,
  input  logic [OCC_W-1:0]   rob_occ_restore,
  output logic [OCC_W-1:0]   rob_occupancy,
  output logic               rob_credit_full,
  output logic [2:0]         starve_flag,
  output logic               err_underflow
);

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(ROB_DEPTH);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT);

  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_next;
  logic [OCC_W-1:0] restore_clamped;
  logic [AGE_W-1:0] age [3];
  logic             err_q;
  logic             underflow;
  logic             credit_full;
  logic [2:0]       eligible;
  logic [2:0]       starved;
  logic [2:0]       gnt;
  logic             gnt_any;
  logic [1:0]       gnt_idx;

  assign credit_full = (occ == OCC_FULL);

  always_comb begin
    eligible = '0;
    starved  = '0;
    for (int i = 0; i < 3; i++) begin
      eligible[i] = disp.req_valid[i] & disp.rs_has_space[i] & ~credit_full & ~mispredict & ~reset;
      starved[i]  = eligible[i] & (age[i] == AGE_MAX);
    end
  end

`ifdef DISPATCH_ARB_RR_EN
  logic [1:0] rr_ptr;
  logic [2:0] rr_sum;
  logic [1:0] rr_cand;
  logic       rr_found;
`endif

  always_comb begin
    gnt = '0;
`ifdef DISPATCH_ARB_RR_EN
    rr_sum   = '0;
    rr_cand  = '0;
    rr_found = 1'b0;
`endif
    if (starved[0])      gnt = 3'b001;
    else if (starved[1]) gnt = 3'b010;
    else if (starved[2]) gnt = 3'b100;
    else begin
`ifdef DISPATCH_ARB_RR_EN
      // Search rr_ptr, rr_ptr+1, rr_ptr+2 modulo 3; first eligible wins.
      for (int k = 0; k < 3; k++) begin
        rr_sum = {1'b0, rr_ptr} + 3'(k);
        if (rr_sum >= 3'd3) rr_sum = rr_sum - 3'd3;
        rr_cand = rr_sum[1:0];
        if (!rr_found && eligible[rr_cand]) begin
          gnt[rr_cand] = 1'b1;
          rr_found     = 1'b1;
        end
      end
`else
      if (eligible[0])      gnt = 3'b001;
      else if (eligible[1]) gnt = 3'b010;
      else if (eligible[2]) gnt = 3'b100;
`endif
    end
  end

  assign gnt_any = |gnt;

  always_comb begin
    gnt_idx = 2'd0;
    if (gnt[1])      gnt_idx = 2'd1;
    else if (gnt[2]) gnt_idx = 2'd2;
  end

  assign disp.grant       = gnt;
  assign disp.grant_valid = gnt_any;
  assign disp.grant_idx   = gnt_idx;

  assign restore_clamped = (rob_occ_restore > OCC_FULL) ? OCC_FULL : rob_occ_restore;

  // A grant paired with a retire nets to zero, even at occ=0.
  always_comb begin
    occ_next  = occ;
    underflow = 1'b0;
    if (mispredict) begin
      occ_next = restore_clamped;
    end else if (gnt_any && !rob_retire) begin
      occ_next = occ + OCC_W'(1);
    end else if (!gnt_any && rob_retire) begin
      if (occ == '0) underflow = 1'b1;
      else           occ_next  = occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ   <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < 3; i++) age[i] <= '0;
    end else begin
      occ   <= occ_next;
      err_q <= err_q | underflow;
      // Ages hold while a valid requester is blocked by RS or credit back-pressure.
      for (int i = 0; i < 3; i++) begin
        if (mispredict || !disp.req_valid[i] || gnt[i]) age[i] <= '0;
        else if (eligible[i] && age[i] != AGE_MAX)        age[i] <= age[i] + AGE_W'(1);
      end
    end
  end

`ifdef DISPATCH_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset)        rr_ptr <= 2'd0;
    else if (gnt_any) rr_ptr <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
  end
`endif

  always_comb begin
    starve_flag = '0;
    for (int i = 0; i < 3; i++) starve_flag[i] = (age[i] == AGE_MAX);
  end

  assign rob_occupancy   = occ;
  assign rob_credit_full = credit_full;
  assign err_underflow   = err_q;

endmodule

// File: tb/tb_dispatch_arbiter.sv
// Directed bench for dispatch_arbiter: reset, credit fill/retire, starvation or round-robin order,
// mispredict restore and clamp, underflow stickiness and mid-operation reset.
module tb_dispatch_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       rob_retire;
  logic       mispredict;
  logic [4:0] rob_occ_restore;
  logic [4:0] rob_occupancy;
  logic       rob_credit_full;
  logic [2:0] starve_flag;
  logic       err_underflow;

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  dispatch_arbiter_if dif();

  dispatch_arbiter #(.ROB_DEPTH(16), .STARVE_LIMIT(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .disp            (dif),
    .rob_retire      (rob_retire),
    .mispredict      (mispredict),
    .rob_occ_restore (rob_occ_restore),
    .rob_occupancy   (rob_occupancy),
    .rob_credit_full (rob_credit_full),
    .starve_flag     (starve_flag),
    .err_underflow   (err_underflow)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1ns after the rising edge, then settle 1ns before checks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] req, input logic [2:0] space, input logic ret,
                       input logic mp, input logic [4:0] restore);
    dif.req_valid    = req;
    dif.rs_has_space = space;
    rob_retire       = ret;
    mispredict       = mp;
    rob_occ_restore  = restore;
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    drive(3'b000, 3'b000, 1'b0, 1'b0, 5'd0);
    repeat (cycles) tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    int grants;
    logic [1:0] exp_idx;

    // Reset held with every requester ready: no grant in either cycle.
    reset = 1'b1;
    drive(3'b111, 3'b111, 1'b0, 1'b0, 5'd0);
    check_eq("reset_grant_c0", dif.grant, 0);
    tick();
    #1;
    check_eq("reset_grant_c1", dif.grant, 0);
    check_eq("reset_gvalid_c1", dif.grant_valid, 0);
    tick();
    reset = 1'b0;
    drive(3'b000, 3'b000, 1'b0, 1'b0, 5'd0);
    check_eq("post_reset_occ", rob_occupancy, 0);
    check_eq("post_reset_full", rob_credit_full, 0);
    check_eq("post_reset_err", err_underflow, 0);
    check_eq("post_reset_starve", starve_flag, 0);
    check_eq("post_reset_idx", dif.grant_idx, 0);

    // Fill all 16 credits with continuous requests.
    grants = 0;
    for (int c = 0; c < 16; c++) begin
      drive(3'b111, 3'b111, 1'b0, 1'b0, 5'd0);
      check_eq("fill_onehot", $countones(dif.grant), 1);
      if (dif.grant_valid) grants++;
      tick();
    end
    check_eq("fill_grants", grants, 16);
    drive(3'b111, 3'b111, 1'b0, 1'b0, 5'd0);
    check_eq("full_flag", rob_credit_full, 1);
    check_eq("full_occ", rob_occupancy, 16);
    check_eq("full_no_grant", dif.grant, 0);
    drive(3'b111, 3'b111, 1'b1, 1'b0, 5'd0);
    check_eq("retire_cycle_no_grant", dif.grant_valid, 0);
    tick();
    drive(3'b111, 3'b111, 1'b0, 1'b0, 5'd0);
    check_eq("after_retire_occ", rob_occupancy, 15);
    check_eq("after_retire_one_grant", dif.grant_valid, 1);
    tick();
    drive(3'b111, 3'b111, 1'b0, 1'b0, 5'd0);
    check_eq("refull_no_grant", dif.grant_valid, 0);
    check_eq("refull_flag", rob_credit_full, 1);

    do_reset(1);

`ifdef DISPATCH_ARB_RR_EN
    // Round-robin order: 0,1,2,0,1,2 with all requesting, then 1,2,1,2 with ALU idle.
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    end
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    end
    for (int c = 0; c < 10; c++) begin
      exp_idx = exp_q.pop_front();
      drive((c < 6) ? 3'b111 : 3'b110, 3'b111, 1'b1, 1'b0, 5'd0);
      check_eq("rr_idx", dif.grant_idx, exp_idx);
      check_eq("rr_valid", dif.grant_valid, 1);
      tick();
    end
`else
    // Fixed priority with LSU waiting: 8 ALU grants, then LSU is forced.
    for (int c = 0; c < 8; c++) exp_q.push_back(2'd0);
    exp_q.push_back(2'd2);
    for (int c = 0; c < 9; c++) begin
      drive(3'b101, 3'b111, 1'b1, 1'b0, 5'd0);
      if (c == 7) check_eq("starve_before_limit", starve_flag, 0);
      if (c == 8) check_eq("starve_at_limit", starve_flag, 3'b100);
      exp_idx = exp_q.pop_front();
      check_eq("fp_idx", dif.grant_idx, exp_idx);
      check_eq("fp_valid", dif.grant_valid, 1);
      tick();
    end
    drive(3'b101, 3'b111, 1'b1, 1'b0, 5'd0);
    check_eq("starve_cleared", starve_flag, 0);
    check_eq("fp_occ_steady", rob_occupancy, 0);
    check_eq("fp_alu_again", dif.grant, 3'b001);
`endif

    // Build occupancy 10, then mispredict with a coincident request and retire.
    do_reset(1);
    for (int c = 0; c < 9; c++) begin
      drive(3'b001, 3'b001, 1'b0, 1'b0, 5'd0);
      tick();
    end
    drive(3'b011, 3'b011, 1'b0, 1'b0, 5'd0);
    tick();
    drive(3'b001, 3'b111, 1'b1, 1'b1, 5'd4);
    check_eq("mp_occ_before", rob_occupancy, 10);
    check_eq("mp_no_grant", dif.grant, 0);
    check_eq("mp_no_gvalid", dif.grant_valid, 0);
    check_eq("mp_idx_zero", dif.grant_idx, 0);
    tick();
    drive(3'b001, 3'b111, 1'b0, 1'b0, 5'd0);
    check_eq("mp_occ_restored", rob_occupancy, 4);
    check_eq("mp_grant_resumes", dif.grant, 3'b001);
    tick();
    check_eq("mp_occ_after_grant", rob_occupancy, 5);

    // Restore above ROB_DEPTH clamps to full.
    drive(3'b000, 3'b000, 1'b0, 1'b1, 5'd20);
    tick();
    drive(3'b111, 3'b111, 1'b0, 1'b0, 5'd0);
    check_eq("clamp_occ", rob_occupancy, 16);
    check_eq("clamp_full", rob_credit_full, 1);
    check_eq("clamp_no_grant", dif.grant_valid, 0);

    // Underflow at occ=0 is sticky.
    drive(3'b000, 3'b000, 1'b0, 1'b1, 5'd0);
    tick();
    drive(3'b000, 3'b000, 1'b1, 1'b0, 5'd0);
    tick();
    drive(3'b000, 3'b000, 1'b0, 1'b0, 5'd0);
    check_eq("uf_occ", rob_occupancy, 0);
    check_eq("uf_err", err_underflow, 1);
    tick();
    check_eq("uf_err_sticky", err_underflow, 1);

    // Grant and retire together at occ=5 leave occupancy unchanged.
    drive(3'b000, 3'b000, 1'b0, 1'b1, 5'd5);
    tick();
    drive(3'b001, 3'b001, 1'b1, 1'b0, 5'd0);
    check_eq("gr_grant", dif.grant_valid, 1);
    tick();
    drive(3'b000, 3'b000, 1'b1, 1'b0, 5'd0);
    check_eq("gr_occ_same", rob_occupancy, 5);
    tick();
    check_eq("retire_only_occ", rob_occupancy, 4);

    // Reset mid-operation drops the pending grant and clears sticky state.
    reset = 1'b1;
    drive(3'b111, 3'b111, 1'b0, 1'b0, 5'd0);
    check_eq("midrst_grant", dif.grant, 0);
    check_eq("midrst_idx", dif.grant_idx, 0);
    tick();
    reset = 1'b0;
    drive(3'b000, 3'b000, 1'b0, 1'b0, 5'd0);
    check_eq("midrst_occ", rob_occupancy, 0);
    check_eq("midrst_err", err_underflow, 0);
    check_eq("midrst_starve", starve_flag, 0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
